calc2_core: RTL and testbench

Parametrised, multi-cycle successor to the team's accumulator CPU. Adds width and register-count parameters, a single shared memory port with a req/ack handshake, a conditional branch and halt/resume control. Fetches 32-bit instructions and data through one port and is the core the SoC memory arbiter connects to.

---
 rtl/calc2_pkg.sv | 30 +++
 rtl/calc2_regfile.sv | 35 +++
 rtl/calc2_core.sv | 177 +++++++++++++++++
 tb/tb_calc2_core.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc2_pkg.sv
// calc2_pkg: shared types and instruction field positions for calc2_core.
//   opcodeE - 3-bit instruction opcodes
//   stateE  - control FSM states
//   OPC_* / RA_MSB / IMM_W - bit positions of the fixed instruction fields
package calc2_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 29;
    localparam int RA_MSB  = 28;
    localparam int IMM_W   = 16;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_MOV  = 3'b011,
        OP_LD   = 3'b100,
        OP_ST   = 3'b101,
        OP_BZ   = 3'b110,
        OP_HALT = 3'b111
    } opcodeE;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } stateE;

endpackage

// File: rtl/calc2_regfile.sv
// calc2_regfile: NREGS x DW register file.
//   Clk, Reset          - clock, asynchronous active-high clear
//   RdAddrA / RdDataA   - asynchronous read port A
//   RdAddrB / RdDataB   - asynchronous read port B
//   WrEn, WrAddr, WrData - synchronous write port
module calc2_regfile #(
    parameter int DW    = 32,
    parameter int NREGS = 4,
    localparam int RB   = $clog2(NREGS)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [RB-1:0] RdAddrA,
    output logic [DW-1:0] RdDataA,
    input  logic [RB-1:0] RdAddrB,
    output logic [DW-1:0] RdDataB,
    input  logic          WrEn,
    input  logic [RB-1:0] WrAddr,
    input  logic [DW-1:0] WrData
);

    logic [DW-1:0] regs [NREGS];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (WrEn) begin
            regs[WrAddr] <= WrData;
        end
    end

    assign RdDataA = regs[RdAddrA];
    assign RdDataB = regs[RdAddrB];

endmodule

// File: rtl/calc2_core.sv
// calc2_core: multi-cycle accumulator CPU with one shared req/ack memory port.
//   Clk, Reset  - clock, asynchronous active-high reset
//   Run         - resume request, only honoured while halted
//   MemReq/MemWe/MemAddr/MemWData - registered memory request (held until MemAck)
//   MemRData, MemAck               - memory response, sampled when MemReq && MemAck
//   Halted, PCOut, AccOut          - status: halt flag, current PC, current R[ACC]
module calc2_core
    import calc2_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 16,
    parameter int NREGS = 4,
    parameter int ACC   = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Run,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    input  logic          MemAck,
    output logic          Halted,
    output logic [AW-1:0] PCOut,
    output logic [DW-1:0] AccOut
);

    localparam int RB = $clog2(NREGS);
    localparam logic [RB-1:0] ACC_IDX = RB'(ACC);

    stateE         state;
    logic [AW-1:0] pc;
    logic [31:0]   ir;

    opcodeE        opc;
    logic [RB-1:0] ra, rd;
    logic [AW-1:0] immA, pcInc, pcExec;
    logic          bzTaken;
    logic [DW-1:0] accVal, raVal, aluRes;
    logic          wrEn;
    logic [RB-1:0] wrAddr;
    logic [DW-1:0] wrData;

    // Bits between rd and imm carry no meaning.
    logic unusedIrBits;
    assign unusedIrBits = ^ir[RA_MSB-2*RB:IMM_W];

    assign opc     = opcodeE'(ir[OPC_MSB:OPC_LSB]);
    assign ra      = ir[RA_MSB -: RB];
    assign rd      = ir[RA_MSB-RB -: RB];
    assign immA    = AW'($signed(ir[IMM_W-1:0]));
    assign pcInc   = pc + AW'(1);
    assign bzTaken = (opc == OP_BZ) && (accVal == '0);
    assign pcExec  = bzTaken ? pc + immA : pcInc;

    calc2_regfile #(.DW(DW), .NREGS(NREGS)) uRegs (
        .Clk     (Clk),
        .Reset   (Reset),
        .RdAddrA (ACC_IDX),
        .RdDataA (accVal),
        .RdAddrB (ra),
        .RdDataB (raVal),
        .WrEn    (wrEn),
        .WrAddr  (wrAddr),
        .WrData  (wrData)
    );

    always_comb begin
        aluRes = accVal;
        case (opc)
            OP_ADD:  aluRes = accVal + raVal;
            OP_SUB:  aluRes = accVal - raVal;
            OP_AND:  aluRes = accVal & raVal;
            default: aluRes = accVal;
        endcase
    end

    // Both operands come from the register array before this edge's write,
    // so ACC-as-source always sees the old value.
    always_comb begin
        wrEn   = 1'b0;
        wrAddr = ACC_IDX;
        wrData = aluRes;
        if (state == S_EXEC) begin
            case (opc)
                OP_ADD, OP_SUB, OP_AND: wrEn = 1'b1;
                OP_MOV: begin
                    wrEn   = 1'b1;
                    wrAddr = rd;
                    wrData = raVal;
                end
                default: ;
            endcase
        end else if (state == S_MEM && MemReq && MemAck && opc == OP_LD) begin
            wrEn   = 1'b1;
            wrAddr = ra;
            wrData = MemRData;
        end
    end

    // Memory-port outputs are loaded on the edge that enters the state
    // using them, so they are registered and stable for the whole transfer.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_FETCH;
            pc       <= '0;
            ir       <= '0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            Halted   <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!MemReq) begin
                        // Only reached straight out of reset.
                        MemReq  <= 1'b1;
                        MemWe   <= 1'b0;
                        MemAddr <= pc;
                    end else if (MemAck) begin
                        ir     <= MemRData[31:0];
                        MemReq <= 1'b0;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (opc)
                        OP_LD, OP_ST: begin
                            MemReq   <= 1'b1;
                            MemWe    <= (opc == OP_ST);
                            MemAddr  <= immA;
                            MemWData <= raVal;
                            state    <= S_MEM;
                        end
                        OP_HALT: begin
                            Halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            pc      <= pcExec;
                            MemReq  <= 1'b1;
                            MemWe   <= 1'b0;
                            MemAddr <= pcExec;
                            state   <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (MemAck) begin
                        // Next fetch request follows back-to-back.
                        pc      <= pcInc;
                        MemWe   <= 1'b0;
                        MemAddr <= pcInc;
                        state   <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (Run) begin
                        Halted  <= 1'b0;
                        pc      <= pcInc;
                        MemReq  <= 1'b1;
                        MemWe   <= 1'b0;
                        MemAddr <= pcInc;
                        state   <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    assign PCOut  = pc;
    assign AccOut = accVal;

endmodule

// File: tb/tb_calc2_core.sv
// tb_calc2_core: random and directed programs checked against an
// instruction-level model of the ISA and its cycle costs.
module tb_calc2_core;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Run = 1'b0;
    logic        MemReq, MemWe, MemAck, Halted;
    logic [15:0] MemAddr, PCOut;
    logic [31:0] MemWData, MemRData, AccOut;

    always #5 Clk = ~Clk;

    calc2_core #(.DW(32), .AW(16), .NREGS(4), .ACC(2)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Run      (Run),
        .MemReq   (MemReq),
        .MemWe    (MemWe),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemRData (MemRData),
        .MemAck   (MemAck),
        .Halted   (Halted),
        .PCOut    (PCOut),
        .AccOut   (AccOut)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
    } xferT;

    xferT        gotQ[$], expQ[$], logX;
    logic [31:0] memInit [int];
    logic [31:0] memDut  [int];
    int          waitN = 0, waitCnt = 0;
    bit          busErr = 0;
    logic        prevReq = 0, prevAck = 0;
    logic [48:0] prevBus = '0;
    int          nTests = 0, nFail = 0;

    localparam logic [2:0] ADD = 0, SUB = 1, AND_ = 2, MOV = 3, LD = 4, ST = 5, BZ = 6, HLT = 7;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [1:0] a,
                                        input logic [1:0] b, input logic [15:0] imm);
        logic [8:0] junk;
        junk = 9'($urandom);
        return {op, a, b, junk, imm};
    endfunction

    function automatic xferT mkX(input logic we, input logic [15:0] a, input logic [31:0] d);
        xferT x;
        x.we = we; x.addr = a; x.data = d;
        return x;
    endfunction

    // Memory: ack after waitN wait cycles, random MemAck/MemRData when idle.
    always @(negedge Clk) begin
        if (MemReq) begin
            if (prevReq && !prevAck && {MemWe, MemAddr, MemWData} != prevBus) busErr = 1;
            prevBus = {MemWe, MemAddr, MemWData};
            if (waitCnt >= waitN) begin
                MemAck   = 1'b1;
                MemRData = memDut.exists(int'(MemAddr)) ? memDut[int'(MemAddr)] : 32'h0;
                waitCnt  = 0;
            end else begin
                MemAck   = 1'b0;
                MemRData = $urandom;
                waitCnt++;
            end
        end else begin
            MemAck   = 1'($urandom_range(0, 1));
            MemRData = $urandom;
            waitCnt  = 0;
        end
        prevReq = MemReq;
        prevAck = MemAck;
    end

    always @(posedge Clk) begin
        if (!Reset && MemReq && MemAck) begin
            logX = mkX(MemWe, MemAddr, MemWe ? MemWData : MemRData);
            gotQ.push_back(logX);
            if (MemWe) memDut[int'(MemAddr)] = MemWData;
        end
    end

    // Instruction-level reference: executes the program, lists the memory
    // transfers it implies and totals the documented per-instruction cycles.
    task automatic modelRun(input int w, output int cyc, output logic [15:0] pc, output logic [31:0] acc);
        logic [31:0] r [4];
        logic [31:0] m [int];
        logic [31:0] ir, d;
        logic [1:0]  a, b;
        logic [15:0] imm;
        m = memInit;
        for (int i = 0; i < 4; i++) r[i] = 0;
        pc = 0; cyc = 0;
        expQ.delete();
        for (int s = 0; s < 1000; s++) begin
            ir = m.exists(int'(pc)) ? m[int'(pc)] : 32'h0;
            expQ.push_back(mkX(1'b0, pc, ir));
            cyc += 2 + w;
            a = ir[28:27]; b = ir[26:25]; imm = ir[15:0];
            case (ir[31:29])
                ADD:  begin r[2] = r[2] + r[a]; pc++; end
                SUB:  begin r[2] = r[2] - r[a]; pc++; end
                AND_: begin r[2] = r[2] & r[a]; pc++; end
                MOV:  begin r[b] = r[a]; pc++; end
                LD: begin
                    d = m.exists(int'(imm)) ? m[int'(imm)] : 32'h0;
                    expQ.push_back(mkX(1'b0, imm, d));
                    r[a] = d; pc++; cyc += 1 + w;
                end
                ST: begin
                    expQ.push_back(mkX(1'b1, imm, r[a]));
                    m[int'(imm)] = r[a]; pc++; cyc += 1 + w;
                end
                BZ: pc = (r[2] == 0) ? pc + imm : pc + 1;
                default: break;
            endcase
        end
        acc = r[2];
    endtask

    task automatic doReset();
        Reset = 1'b1;
        Run   = 1'b0;
        repeat (3) @(negedge Clk);
        gotQ.delete();
        busErr = 0;
        Reset = 1'b0;
    endtask

    task automatic waitHalt(input string tag, input int limit);
        int t;
        t = 0;
        while (!Halted && t < limit) begin
            @(negedge Clk);
            t++;
        end
        check({tag, "_halt_reached"}, Halted, 1);
    endtask

    task automatic runProg(input string tag, input int w, output int cyc);
        int          t, expCyc;
        bit          seen;
        logic [15:0] expPc;
        logic [31:0] expAcc;
        int          n;
        memDut = memInit;
        waitN  = w;
        modelRun(w, expCyc, expPc, expAcc);
        doReset();
        t = 0; cyc = -1; seen = 0;
        while (!Halted && t < 2000) begin
            @(negedge Clk);
            t++;
            if (MemReq) seen = 1;
            if (seen) cyc++;
        end
        check({tag, "_halt_reached"}, Halted, 1);
        check({tag, "_cycles"}, 64'(cyc), 64'(expCyc));
        check({tag, "_pc"}, PCOut, expPc);
        check({tag, "_acc"}, AccOut, expAcc);
        check({tag, "_nxfer"}, gotQ.size(), expQ.size());
        check({tag, "_bus_stable"}, busErr, 0);
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < n; i++)
            check({tag, "_xfer"}, {gotQ[i].we, gotQ[i].addr, gotQ[i].data},
                  {expQ[i].we, expQ[i].addr, expQ[i].data});
    endtask

    initial begin
        int cyc;
        logic [2:0]  op;
        logic [15:0] imm;

        // Reset state
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_memreq", MemReq, 0);
        check("rst_memwe", MemWe, 0);
        check("rst_memaddr", MemAddr, 0);
        check("rst_wdata", MemWData, 0);
        check("rst_halted", Halted, 0);
        check("rst_pc", PCOut, 0);
        check("rst_acc", AccOut, 0);
        Reset = 1'b0;
        @(negedge Clk);
        check("first_req", {MemReq, MemWe, MemAddr}, {1'b1, 1'b0, 16'h0});

        // LD then ADD, zero-wait and 3-wait
        memInit.delete();
        memInit[0] = enc(LD, 1, 0, 16'h0010);
        memInit[1] = enc(ADD, 1, 0, 16'h0);
        memInit[2] = enc(HLT, 0, 0, 16'h0);
        memInit[16'h10] = 32'd5;
        runProg("alu_w0", 0, cyc);
        check("alu_w0_acc5", AccOut, 5);
        check("alu_w0_cyc7", 64'(cyc), 7);
        runProg("alu_w3", 3, cyc);
        check("alu_w3_acc5", AccOut, 5);
        check("alu_w3_cyc19", 64'(cyc), 19);

        // Branches: taken backwards at PC=4, then not taken at PC=4
        memInit.delete();
        memInit[0] = enc(LD, 1, 0, 16'h0011);
        memInit[1] = enc(BZ, 0, 0, 16'd3);
        memInit[2] = enc(ADD, 1, 0, 16'h0);
        memInit[3] = enc(BZ, 0, 0, 16'd2);
        memInit[4] = enc(BZ, 0, 0, 16'hFFFE);
        memInit[5] = enc(HLT, 0, 0, 16'h0);
        memInit[16'h11] = 32'd1;
        runProg("bz", 0, cyc);
        if (gotQ.size() == 8) begin
            check("bz_taken_addr", gotQ[4].addr, 16'd2);
            check("bz_nottaken_addr", gotQ[7].addr, 16'd5);
        end
        check("bz_final_pc", PCOut, 5);

        // PC wrap 0xFFFF -> 0x0000 on a non-branch instruction
        memInit.delete();
        memInit[0] = enc(BZ, 0, 0, 16'hFFFF);
        memInit[16'hFFFF] = enc(LD, 2, 0, 16'h0012);
        memInit[1] = enc(HLT, 0, 0, 16'h0);
        memInit[16'h12] = 32'd7;
        runProg("wrap", 1, cyc);
        if (gotQ.size() == 5) check("wrap_fetch0", gotQ[3].addr, 16'h0);
        check("wrap_pc", PCOut, 1);

        // SUB 0-1, ST 0xFFFFFFFF, ADD wrap to 0
        memInit.delete();
        memInit[0] = enc(LD, 1, 0, 16'h0013);
        memInit[1] = enc(SUB, 1, 0, 16'h0);
        memInit[2] = enc(ST, 2, 0, 16'h0020);
        memInit[3] = enc(ADD, 1, 0, 16'h0);
        memInit[4] = enc(HLT, 0, 0, 16'h0);
        memInit[16'h13] = 32'd1;
        runProg("st", 2, cyc);
        if (gotQ.size() == 7)
            check("st_write", {gotQ[4].we, gotQ[4].addr, gotQ[4].data}, {1'b1, 16'h20, 32'hFFFFFFFF});
        check("st_mem", memDut.exists(32'h20) ? memDut[32'h20] : 32'h0, 32'hFFFFFFFF);
        check("st_add_wrap", AccOut, 0);

        // Halt / resume; early Run must be ignored
        memInit.delete();
        for (int i = 0; i < 7; i++) memInit[i] = enc(ADD, 0, 0, 16'h0);
        memInit[7] = enc(HLT, 0, 0, 16'h0);
        memInit[8] = enc(HLT, 0, 0, 16'h0);
        memDut = memInit;
        waitN = 0;
        doReset();
        repeat (2) @(negedge Clk);
        Run = 1'b1;
        repeat (5) @(negedge Clk);
        Run = 1'b0;
        waitHalt("halt1", 100);
        repeat (2) @(negedge Clk);
        check("halt_state", {Halted, MemReq, PCOut}, {1'b1, 1'b0, 16'd7});
        check("halt_nfetch", gotQ.size(), 8);
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        check("resume_req", {Halted, MemReq, MemWe, MemAddr}, {1'b0, 1'b1, 1'b0, 16'd8});
        waitHalt("halt2", 100);
        check("halt2_pc", PCOut, 8);

        // Reset during a stalled ST
        memInit.delete();
        memInit[0] = enc(ST, 0, 0, 16'h0030);
        memInit[1] = enc(HLT, 0, 0, 16'h0);
        memDut = memInit;
        waitN = 0;
        doReset();
        @(negedge Clk);
        @(negedge Clk);
        #1 waitN = 1000;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        check("midrst_pending", {MemReq, MemWe, MemAddr}, {1'b1, 1'b1, 16'h30});
        Reset = 1'b1;
        #1;
        check("midrst_req_drop", MemReq, 0);
        check("midrst_pc", PCOut, 0);
        repeat (2) @(negedge Clk);
        check("midrst_no_write", memDut.exists(32'h30), 0);
        gotQ.delete();
        waitN = 0;
        Reset = 1'b0;
        for (int t = 0; t < 20 && gotQ.size() == 0; t++) @(negedge Clk);
        check("midrst_refetch", gotQ.size() > 0 ? {gotQ[0].we, gotQ[0].addr} : 17'h1FFFF, {1'b0, 16'h0});

        // Random programs, forward-only branches
        for (int p = 0; p < 20; p++) begin
            memInit.delete();
            for (int i = 0; i < 8; i++) memInit[32'h40 + i] = $urandom;
            for (int pc = 0; pc < 12; pc++) begin
                op = 3'($urandom_range(0, 6));
                if (op == LD || op == ST) imm = 16'h40 + 16'($urandom_range(0, 7));
                else if (op == BZ)        imm = 16'($urandom_range(1, 3));
                else                      imm = 16'($urandom);
                memInit[pc] = enc(op, 2'($urandom), 2'($urandom), imm);
            end
            for (int pc = 12; pc < 16; pc++) memInit[pc] = enc(HLT, 0, 0, 16'h0);
            runProg("rnd", $urandom_range(0, 3), cyc);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
